// File: rtl/gray_bcd_pkg.sv
// gray_bcd_pkg: shared constants and types for the Gray-coded BCD decoder.
//   DIGIT_W : width of one digit (Gray and binary alike)
//   BCD_MAX : largest legal decoded digit value
//   state_e : decoder FSM states
package gray_bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/gray_digit_step.sv
// gray_digit_step: one bit-serial Gray-to-binary step for a single digit.
// Ports:
//   g_i : Gray code of the digit (latched word)
//   b_i : partially decoded binary (bits above k already valid)
//   k_i : bit index being resolved this step, 3 down to 0
//   b_o : b_i with bit k resolved
module gray_digit_step
  import gray_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] g_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic [1:0]         k_i,
  output logic [DIGIT_W-1:0] b_o
);

  always_comb begin
    b_o = b_i;
    if (k_i == 2'd3) begin
      b_o[3] = g_i[3];
    end else begin
      b_o[k_i] = b_i[2'(k_i + 2'd1)] ^ g_i[k_i];
    end
  end

endmodule

// File: rtl/gray_to_bcd_serial.sv
// gray_to_bcd_serial: bit-serial decoder for words of Gray-coded BCD digits.
// All digits are decoded in parallel, MSB first, one bit per cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_gray is DIGITS packed Gray digits
//   out_valid/out_ready  : output handshake for out_bcd/out_err/err_mask
//   out_bcd              : decoded binary per digit (10..15 passed through unclamped)
//   out_err, err_mask    : any / per-digit decoded value above 9
//   err_count            : saturating count of erroneous words
module gray_to_bcd_serial
  import gray_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_gray,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      out_err,
  output logic [DIGITS-1:0]         err_mask,
  output logic [ERRW-1:0]           err_count
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  state_e            state_q, state_d;
  logic [W-1:0]      gray_q, gray_d;
  logic [W-1:0]      work_q, work_d;
  logic [1:0]        k_q, k_d;
  logic [W-1:0]      bcd_q, bcd_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              err_q, err_d;
  logic [ERRW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      step_b;

  for (genvar d = 0; d < DIGITS; d++) begin : g_step
    gray_digit_step u_step (
      .g_i (gray_q[DIGIT_W*d +: DIGIT_W]),
      .b_i (work_q[DIGIT_W*d +: DIGIT_W]),
      .k_i (k_q),
      .b_o (step_b[DIGIT_W*d +: DIGIT_W])
    );
  end

  // Decoding runs in a private work register so the published outputs
  // hold their previous word until the new one is complete.
  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    work_d  = work_q;
    k_d     = k_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          gray_d  = in_gray;
          work_d  = '0;
          k_d     = 2'd3;
          state_d = DECODE;
        end
      end
      DECODE: begin
        work_d = step_b;
        k_d    = k_q - 2'd1;
        if (k_q == 2'd0) begin
          state_d = DONE;
          bcd_d   = step_b;
          for (int unsigned d = 0; d < DIGITS; d++) begin
            mask_d[d] = (step_b[DIGIT_W*d +: DIGIT_W] > BCD_MAX);
          end
          err_d = |mask_d;
          if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERRW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gray_q  <= '0;
      work_q  <= '0;
      k_q     <= 2'd3;
      bcd_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      work_q  <= work_d;
      k_q     <= k_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_err   = err_q;
  assign err_mask  = mask_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_to_bcd_serial.sv
// tb_gray_to_bcd_serial: randomized self-checking bench for gray_to_bcd_serial
// (DIGITS=2, ERRW=8) against an arithmetic Gray-to-binary reference model.
module tb_gray_to_bcd_serial;

  localparam int DIGITS = 2;
  localparam int ERRW   = 8;
  localparam int W      = 4 * DIGITS;
  localparam int CMAX   = (1 << ERRW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_gray;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_bcd;
  logic              out_err;
  logic [DIGITS-1:0] err_mask;
  logic [ERRW-1:0]   err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  gray_to_bcd_serial #(.DIGITS(DIGITS), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .err_mask  (err_mask),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic int g2b(input int g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  task automatic run_word(input logic [W-1:0] g, input int hold);
    logic [W-1:0]      exp_bcd;
    logic [DIGITS-1:0] exp_mask;
    int wc, lat, v;
    exp_bcd  = '0;
    exp_mask = '0;
    for (int d = 0; d < DIGITS; d++) begin
      v = g2b(int'(g[4*d +: 4]));
      exp_bcd[4*d +: 4] = 4'(v);
      exp_mask[d] = (v > 9);
    end
    if (exp_mask != '0 && model_cnt < CMAX) model_cnt++;

    wc = 0;
    while (!in_ready && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_gray  = g;
    @(negedge clk);

    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_gray   = W'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 32'(lat), 32'd4);
    check("out_bcd", 32'(out_bcd), 32'(exp_bcd));
    check("err_mask", 32'(err_mask), 32'(exp_mask));
    check("out_err", 32'(out_err), 32'(exp_mask != '0));
    check("err_count", 32'(err_count), 32'(model_cnt));
    check("in_ready_done", 32'(in_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      in_gray  = W'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_bcd", 32'(out_bcd), 32'(exp_bcd));
      check("bp_mask", 32'(err_mask), 32'(exp_mask));
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("hold_bcd", 32'(out_bcd), 32'(exp_bcd));
    check("hold_count", 32'(err_count), 32'(model_cnt));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_bcd"}, 32'(out_bcd), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_err_mask"}, 32'(err_mask), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_gray   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Directed words
    run_word(8'b0000_0100, 0);   // digit 0: 0100 -> 7
    run_word(8'b1101_0011, 2);   // -> 0x92, no error
    run_word(8'b1111_0000, 10);  // -> 0xA0, mask 10, count 1

    // All 16 codes in each digit, out_ready effectively held high
    for (int g = 0; g < 16; g++) begin
      run_word({4'(g), 4'(15 - g)}, 0);
    end

    // Random words with random backpressure
    for (int i = 0; i < 40; i++) begin
      run_word(W'($urandom), $urandom_range(0, 3));
    end

    // Reset in the 2nd DECODE cycle discards the word and clears the counter
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_gray  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    check_reset_values("mid_reset");

    // Counter saturation
    for (int i = 0; i < CMAX + 5; i++) begin
      run_word(8'b1000_1111, 0);
    end
    check("sat_count", 32'(err_count), 32'(CMAX));

    // Reset while in DONE
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_gray  = 8'h12;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_done_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    check_reset_values("done_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_to_bcd_serial.md
Name: gray_to_bcd_serial

Overview:
Sequential decoder for the Gray-coded BCD digits produced by our BCD-to-Gray encoder.
- Accepts a packed word of DIGITS 4-bit Gray codes.
- Recovers each BCD digit bit-serially, MSB first: 4 cycles per word, all digits in parallel.
- Flags any digit that decodes outside 0–9.
- Sits on the receive side of any path carrying Gray-encoded BCD, with valid/ready handshakes on both ends.

Parameters:
- DIGITS, 2, number of 4-bit digits per word (≥1).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_gray holds a word.
- in_ready  output  1  block can accept a word.
- in_gray  input  4*DIGITS  Gray digits; digit d is at [4d+3:4d], digit 0 is the LSD.
- out_valid  output  1  out_bcd, out_err and err_mask are valid.
- out_ready  input  1  consumer takes the result.
- out_bcd  output  4*DIGITS  decoded binary per digit, same packing as in_gray.
- out_err  output  1  at least one digit decoded to a value greater than 9.
- err_mask  output  DIGITS  bit d set when digit d decoded to a value greater than 9.
- err_count  output  ERRW  count of erroneous words; saturates.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_bcd=0; out_err=0; err_mask=0; err_count=0; bit index=3.
- FSM states: IDLE, DECODE, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_gray, clear the bcd register, bit index k=3, go to DECODE.
- DECODE:
  - in_ready=0.
  - Each edge computes bit k of every digit:
    - b[3]=g[3]
    - b[k]=b[k+1]^g[k] for k<3
  - Then k decrements.
  - After the edge that computes k=0 (the 4th DECODE edge), go to DONE.
  - On that same edge, register err_mask[d]=(b_d>9) and out_err=|err_mask.
  - If out_err=1, increment err_count, saturating at 2^ERRW-1.
- DONE:
  - out_valid=1. out_bcd, out_err and err_mask are stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_valid deasserts the next cycle; outputs keep their last values until the next word completes.
- Latency:
  - Word accepted at edge N; out_valid=1 in the cycle following edge N+4.
  - Throughput: at most 1 word per 6 cycles with out_ready held high.
- Invalid codes (Gray 1111, 1110, 1010, 1011, 1001, 1000):
  - out_bcd shows the raw binary (10–15) with the corresponding err_mask bit set.
  - No digit is clamped.
- Backpressure: DONE holds indefinitely; outputs must not change while out_valid=1 and out_ready=0.
- in_gray changing during DECODE has no effect, because the word is latched.
- Reset in any state, including mid-DECODE or DONE: the word is discarded and all outputs return to reset values on that edge.
- err_count is cleared only by rst.
- Handshake inputs are ignored outside their own state: in_valid outside IDLE, out_ready outside DONE.

Decomposition:
- Shared package gray_bcd_pkg holds:
  - state encoding constants (IDLE=2'd0, DECODE=2'd1, DONE=2'd2);
  - BCD_MAX=4'd9;
  - the digit width constant 4.
- One natural sub-module, gray_digit_step:
  - one digit's combinational step;
  - inputs g, partial b, k; outputs next b;
  - instantiated DIGITS times.
- FSM, counters and handshake stay in the top.

Test Plan:
1. DIGITS=1, in_gray=0100 accepted at edge N → out_valid=1 after edge N+4, out_bcd=0111, out_err=0.
2. DIGITS=2, in_gray=8'b1101_0011 → out_bcd=8'h92, err_mask=00, err_count unchanged.
3. DIGITS=2, in_gray=8'b1111_0000 → out_bcd=8'hA0, err_mask=10, out_err=1, err_count=1.
4. Exhaustive sweep of all 16 Gray codes per digit, out_ready=1 → out_bcd equals Gray-to-binary of each; err_mask set exactly for codes 1111, 1110, 1010, 1011, 1001, 1000.
5. Backpressure: out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0. Then pulse out_ready → IDLE next cycle, in_ready=1.
6. Reset and saturation:
   - Assert rst at the 2nd DECODE cycle → next cycle out_valid=0, in_ready=1, out_bcd=0, err_count=0.
   - With ERRW=2, send 5 invalid words → err_count=3.
